mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register. Reads the registered EX/MEM fields and runs the data-memory access through a request/ready handshake.
- Owns the architectural stack pointer (SP) and applies push/pop updates.
- Drives stall back to the EX/MEM buffer and the front of the pipe while an access is outstanding.
- Presents registered fields to the MEM/WB buffer.

---
 rtl/mem_stage_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// EX/MEM consumer: sequences the data-memory request/ready handshake, owns the
// architectural stack pointer and presents registered fields to MEM/WB.
module mem_stage_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iRegWrite,
    input  logic              iMemOrReg,
    input  logic              iDestOrPrivate,
    input  logic              iSPOrALUres,
    input  logic              iMemWrite,
    input  logic              iMemRead,
    input  logic [3:0]        iRegDestAddress,
    input  logic [15:0]       iALUResult,
    input  logic [15:0]       iRegSrc,
    input  logic [1:0]        iSPOpeartion,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              oRegWrite,
    output logic              oMemOrReg,
    output logic              oDestOrPrivate,
    output logic              oValid,
    output logic [3:0]        oRegDestAddress,
    output logic [15:0]       oALUResult,
    output logic [15:0]       oMemData,
    output logic [15:0]       oSP,
    output logic              oMemErr
);
    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;

    // Copies of the EX/MEM fields taken when an access is issued.
    logic              h_regwrite_q, h_regwrite_d;
    logic              h_memorreg_q, h_memorreg_d;
    logic              h_destpriv_q, h_destpriv_d;
    logic [3:0]        h_dest_q, h_dest_d;
    logic [15:0]       h_alu_q, h_alu_d;
    logic [1:0]        h_spop_q, h_spop_d;

    logic              o_regwrite_q, o_regwrite_d;
    logic              o_memorreg_q, o_memorreg_d;
    logic              o_destpriv_q, o_destpriv_d;
    logic              o_valid_q, o_valid_d;
    logic [3:0]        o_dest_q, o_dest_d;
    logic [15:0]       o_alu_q, o_alu_d;
    logic [15:0]       o_memdata_q, o_memdata_d;
    logic              err_q, err_d;

    logic              acc;
    logic [ADDR_W-1:0] sel_addr;

    function automatic logic [ADDR_W-1:0] sp_apply(input logic [ADDR_W-1:0] sp,
                                                   input logic [1:0]        op);
        case (op)
            2'b01:   return sp - SP_ONE;
            2'b10:   return sp + SP_ONE;
            default: return sp;
        endcase
    endfunction

    assign acc      = iMemRead | iMemWrite;
    // A pop reads the slot just above the current top of stack.
    assign sel_addr = !iSPOrALUres            ? iALUResult[ADDR_W-1:0] :
                      (iSPOpeartion == 2'b10) ? sp_q + SP_ONE          : sp_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sp_d         = sp_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        h_regwrite_d = h_regwrite_q;
        h_memorreg_d = h_memorreg_q;
        h_destpriv_d = h_destpriv_q;
        h_dest_d     = h_dest_q;
        h_alu_d      = h_alu_q;
        h_spop_d     = h_spop_q;
        o_regwrite_d = o_regwrite_q;
        o_memorreg_d = o_memorreg_q;
        o_destpriv_d = o_destpriv_q;
        o_valid_d    = o_valid_q;
        o_dest_d     = o_dest_q;
        o_alu_d      = o_alu_q;
        o_memdata_d  = o_memdata_q;
        err_d        = err_q;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    stall        = 1'b1;
                    req_d        = 1'b1;
                    we_d         = iMemWrite;
                    addr_d       = sel_addr;
                    wdata_d      = iRegSrc;
                    cnt_d        = '0;
                    h_regwrite_d = iRegWrite;
                    h_memorreg_d = iMemOrReg;
                    h_destpriv_d = iDestOrPrivate;
                    h_dest_d     = iRegDestAddress;
                    h_alu_d      = iALUResult;
                    h_spop_d     = iSPOpeartion;
                    o_valid_d    = 1'b0;
                    o_regwrite_d = 1'b0;
                    state_d      = BUSY;
                end else begin
                    o_regwrite_d = iRegWrite;
                    o_memorreg_d = iMemOrReg;
                    o_destpriv_d = iDestOrPrivate;
                    o_dest_d     = iRegDestAddress;
                    o_alu_d      = iALUResult;
                    o_memdata_d  = 16'h0000;
                    o_valid_d    = 1'b1;
                    sp_d         = sp_apply(sp_q, iSPOpeartion);
                end
            end
            BUSY: begin
                o_valid_d    = 1'b0;
                o_regwrite_d = 1'b0;
                if (mem_ready) begin
                    o_regwrite_d = h_regwrite_q;
                    o_memorreg_d = h_memorreg_q;
                    o_destpriv_d = h_destpriv_q;
                    o_dest_d     = h_dest_q;
                    o_alu_d      = h_alu_q;
                    o_memdata_d  = we_q ? 16'h0000 : mem_rdata;
                    o_valid_d    = 1'b1;
                    sp_d         = sp_apply(sp_q, h_spop_q);
                    req_d        = 1'b0;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    // Abort releases the pipe; the access is dropped without touching SP.
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sp_q         <= '1;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            h_regwrite_q <= 1'b0;
            h_memorreg_q <= 1'b0;
            h_destpriv_q <= 1'b0;
            h_dest_q     <= '0;
            h_alu_q      <= '0;
            h_spop_q     <= '0;
            o_regwrite_q <= 1'b0;
            o_memorreg_q <= 1'b0;
            o_destpriv_q <= 1'b0;
            o_valid_q    <= 1'b0;
            o_dest_q     <= '0;
            o_alu_q      <= '0;
            o_memdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sp_q         <= sp_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            h_regwrite_q <= h_regwrite_d;
            h_memorreg_q <= h_memorreg_d;
            h_destpriv_q <= h_destpriv_d;
            h_dest_q     <= h_dest_d;
            h_alu_q      <= h_alu_d;
            h_spop_q     <= h_spop_d;
            o_regwrite_q <= o_regwrite_d;
            o_memorreg_q <= o_memorreg_d;
            o_destpriv_q <= o_destpriv_d;
            o_valid_q    <= o_valid_d;
            o_dest_q     <= o_dest_d;
            o_alu_q      <= o_alu_d;
            o_memdata_q  <= o_memdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign oRegWrite       = o_regwrite_q;
    assign oMemOrReg       = o_memorreg_q;
    assign oDestOrPrivate  = o_destpriv_q;
    assign oValid          = o_valid_q;
    assign oRegDestAddress = o_dest_q;
    assign oALUResult      = o_alu_q;
    assign oMemData        = o_memdata_q;
    assign oSP             = 16'(sp_q);
    assign oMemErr         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level SP/address model.
module tb_mem_stage_ctrl;
    localparam int ADDR_W   = 11;
    localparam int MAX_WAIT = 15;
    localparam int SPMOD    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              iRegWrite, iMemOrReg, iDestOrPrivate, iSPOrALUres;
    logic              iMemWrite, iMemRead;
    logic [3:0]        iRegDestAddress;
    logic [15:0]       iALUResult, iRegSrc;
    logic [1:0]        iSPOpeartion;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic [15:0]       mem_rdata;
    logic              stall;
    logic              oRegWrite, oMemOrReg, oDestOrPrivate, oValid;
    logic [3:0]        oRegDestAddress;
    logic [15:0]       oALUResult, oMemData, oSP;
    logic              oMemErr;

    int n_checks = 0;
    int n_err    = 0;
    int model_sp;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .iRegWrite(iRegWrite), .iMemOrReg(iMemOrReg), .iDestOrPrivate(iDestOrPrivate),
        .iSPOrALUres(iSPOrALUres), .iMemWrite(iMemWrite), .iMemRead(iMemRead),
        .iRegDestAddress(iRegDestAddress), .iALUResult(iALUResult), .iRegSrc(iRegSrc),
        .iSPOpeartion(iSPOpeartion),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .oRegWrite(oRegWrite), .oMemOrReg(oMemOrReg), .oDestOrPrivate(oDestOrPrivate),
        .oValid(oValid), .oRegDestAddress(oRegDestAddress), .oALUResult(oALUResult),
        .oMemData(oMemData), .oSP(oSP), .oMemErr(oMemErr)
    );

    function automatic int m_sp(input int sp, input logic [1:0] op);
        if (op == 2'b01) return (sp + SPMOD - 1) % SPMOD;
        if (op == 2'b10) return (sp + 1) % SPMOD;
        return sp;
    endfunction

    function automatic int m_addr(input int sp, input logic spo, input logic [1:0] op,
                                  input logic [15:0] alu);
        if (!spo) return int'(alu) % SPMOD;
        if (op == 2'b10) return (sp + 1) % SPMOD;
        return sp;
    endfunction

    task automatic drive_nop();
        iRegWrite = 0; iMemOrReg = 0; iDestOrPrivate = 0; iSPOrALUres = 0;
        iMemWrite = 0; iMemRead = 0; iRegDestAddress = 0; iALUResult = 0;
        iRegSrc = 0; iSPOpeartion = 0;
    endtask

    task automatic drive_ex(input logic rw, input logic mor, input logic dop, input logic spo,
                            input logic mw, input logic mr, input logic [3:0] dest,
                            input logic [15:0] alu, input logic [15:0] src, input logic [1:0] op);
        iRegWrite = rw; iMemOrReg = mor; iDestOrPrivate = dop; iSPOrALUres = spo;
        iMemWrite = mw; iMemRead = mr; iRegDestAddress = dest; iALUResult = alu;
        iRegSrc = src; iSPOpeartion = op;
    endtask

    // Issues one access, answers after nwait BUSY cycles, and reports what was observed.
    task automatic run_access(input logic mw, input logic mr, input logic spo, input logic [1:0] op,
                              input logic [15:0] alu, input logic [15:0] src, input logic [15:0] rdata,
                              input int nwait,
                              output logic [ADDR_W-1:0] a, output logic we, output logic [15:0] wd,
                              output logic bub, output int scnt, output logic s_rdy,
                              output logic ov, output logic orw, output logic [15:0] omd,
                              output logic [15:0] osp, output logic req_after);
        @(negedge clk);
        drive_ex(1'b1, mr, 1'b0, spo, mw, mr, 4'd5, alu, src, op);
        mem_ready = 1'b0;
        scnt = 0;
        #1 if (stall) scnt++;
        @(posedge clk); @(negedge clk);
        a = mem_addr; we = mem_we; wd = mem_wdata; bub = oValid | oRegWrite;
        for (int k = 0; k < nwait; k++) begin
            #1 if (stall) scnt++;
            @(posedge clk); @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        #1 s_rdy = stall;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        ov = oValid; orw = oRegWrite; omd = oMemData; osp = oSP; req_after = mem_req;
        drive_nop();
    endtask

    task automatic test_reset();
        rst = 1'b0; drive_nop(); mem_ready = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        n_checks++; if (oValid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", oValid); end
        n_checks++; if (oSP !== 16'h07FF) begin n_err++; $display("FAIL rst_sp got=%h exp=07ff", oSP); end
        n_checks++; if (oMemErr !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", oMemErr); end
        n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", stall); end
        rst = 1'b1;
        model_sp = SPMOD - 1;
    endtask

    task automatic test_alu_pass();
        logic s;
        @(negedge clk);
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 16'h1234, 16'h0, 2'b00);
        #1 s = stall;
        @(posedge clk); @(negedge clk);
        n_checks++; if (s !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b exp=0", s); end
        n_checks++; if (oValid !== 1'b1) begin n_err++; $display("FAIL alu_valid got=%b exp=1", oValid); end
        n_checks++; if (oRegWrite !== 1'b1) begin n_err++; $display("FAIL alu_regwrite got=%b exp=1", oRegWrite); end
        n_checks++; if (oALUResult !== 16'h1234) begin n_err++; $display("FAIL alu_result got=%h exp=1234", oALUResult); end
        n_checks++; if ({oMemOrReg, oDestOrPrivate, oRegDestAddress} !== {1'b1, 1'b1, 4'hA})
            begin n_err++; $display("FAIL alu_fields got=%b%b%h exp=11a", oMemOrReg, oDestOrPrivate, oRegDestAddress); end
        n_checks++; if (oMemData !== 16'h0) begin n_err++; $display("FAIL alu_memdata got=%h exp=0000", oMemData); end
        n_checks++; if (oSP !== 16'h07FF) begin n_err++; $display("FAIL alu_sp got=%h exp=07ff", oSP); end
        drive_nop();
    endtask

    task automatic test_load();
        logic [ADDR_W-1:0] a; logic we, bub, s_rdy, ov, orw, req; logic [15:0] wd, omd, osp; int scnt;
        run_access(1'b0, 1'b1, 1'b0, 2'b00, 16'h0042, 16'h0, 16'hBEEF, 2,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (a !== 11'h042) begin n_err++; $display("FAIL load_addr got=%h exp=042", a); end
        n_checks++; if (we !== 1'b0) begin n_err++; $display("FAIL load_we got=%b exp=0", we); end
        n_checks++; if (bub !== 1'b0) begin n_err++; $display("FAIL load_bubble got=%b exp=0", bub); end
        n_checks++; if (scnt !== 3) begin n_err++; $display("FAIL load_stall_cycles got=%0d exp=3", scnt); end
        n_checks++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL load_stall_ready got=%b exp=0", s_rdy); end
        n_checks++; if (omd !== 16'hBEEF) begin n_err++; $display("FAIL load_data got=%h exp=beef", omd); end
        n_checks++; if (ov !== 1'b1 || orw !== 1'b1) begin n_err++; $display("FAIL load_valid got=%b%b exp=11", ov, orw); end
        n_checks++; if (req !== 1'b0) begin n_err++; $display("FAIL load_req_drop got=%b exp=0", req); end
    endtask

    task automatic test_push_pop();
        logic [ADDR_W-1:0] a; logic we, bub, s_rdy, ov, orw, req; logic [15:0] wd, omd, osp; int scnt;
        run_access(1'b1, 1'b0, 1'b1, 2'b01, 16'h0, 16'hA5A5, 16'h0, 0,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (a !== 11'h7FF) begin n_err++; $display("FAIL push_addr got=%h exp=7ff", a); end
        n_checks++; if (we !== 1'b1) begin n_err++; $display("FAIL push_we got=%b exp=1", we); end
        n_checks++; if (wd !== 16'hA5A5) begin n_err++; $display("FAIL push_wdata got=%h exp=a5a5", wd); end
        n_checks++; if (osp !== 16'h07FE) begin n_err++; $display("FAIL push_sp got=%h exp=07fe", osp); end
        n_checks++; if (omd !== 16'h0) begin n_err++; $display("FAIL push_memdata got=%h exp=0000", omd); end
        run_access(1'b0, 1'b1, 1'b1, 2'b10, 16'h0, 16'h0, 16'hA5A5, 1,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (a !== 11'h7FF) begin n_err++; $display("FAIL pop_addr got=%h exp=7ff", a); end
        n_checks++; if (omd !== 16'hA5A5) begin n_err++; $display("FAIL pop_data got=%h exp=a5a5", omd); end
        n_checks++; if (osp !== 16'h07FF) begin n_err++; $display("FAIL pop_sp got=%h exp=07ff", osp); end
        model_sp = SPMOD - 1;
    endtask

    task automatic test_pop_wrap();
        logic [ADDR_W-1:0] a; logic we, bub, s_rdy, ov, orw, req; logic [15:0] wd, omd, osp; int scnt;
        run_access(1'b0, 1'b1, 1'b1, 2'b10, 16'h0, 16'h0, 16'h1111, 0,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (a !== 11'h000) begin n_err++; $display("FAIL wrap_pop_addr got=%h exp=000", a); end
        n_checks++; if (osp !== 16'h0000) begin n_err++; $display("FAIL wrap_pop_sp got=%h exp=0000", osp); end
        run_access(1'b1, 1'b0, 1'b1, 2'b01, 16'h0, 16'h2222, 16'h0, 0,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (a !== 11'h000) begin n_err++; $display("FAIL wrap_push_addr got=%h exp=000", a); end
        n_checks++; if (osp !== 16'h07FF) begin n_err++; $display("FAIL wrap_push_sp got=%h exp=07ff", osp); end
        model_sp = SPMOD - 1;
    endtask

    task automatic test_timeout();
        int busy, k; logic s_issue;
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 16'h0100, 16'h0, 2'b01);
        mem_ready = 1'b0;
        #1 s_issue = stall;
        @(posedge clk); @(negedge clk); #1;
        busy = 0; k = 0;
        while (stall === 1'b1 && k < 40) begin
            busy++;
            @(posedge clk); @(negedge clk); #1;
            k++;
        end
        n_checks++; if (s_issue !== 1'b1) begin n_err++; $display("FAIL tmo_issue_stall got=%b exp=1", s_issue); end
        n_checks++; if (k >= 40) begin n_err++; $display("FAIL tmo_bound stall still=%b after %0d cycles", stall, k); end
        n_checks++; if (busy !== MAX_WAIT) begin n_err++; $display("FAIL tmo_busy_cycles got=%0d exp=%0d", busy, MAX_WAIT); end
        @(posedge clk); @(negedge clk);
        drive_nop();
        n_checks++; if (oMemErr !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", oMemErr); end
        n_checks++; if (oValid !== 1'b0) begin n_err++; $display("FAIL tmo_bubble got=%b exp=0", oValid); end
        n_checks++; if (oSP !== 16'(model_sp)) begin n_err++; $display("FAIL tmo_sp got=%h exp=%h", oSP, 16'(model_sp)); end
        n_checks++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL tmo_req got=%b exp=0", mem_req); end
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'h5A5A, 16'h0, 2'b00);
        @(posedge clk); @(negedge clk);
        drive_nop();
        n_checks++; if (oValid !== 1'b1 || oALUResult !== 16'h5A5A)
            begin n_err++; $display("FAIL tmo_next_alu got=%b/%h exp=1/5a5a", oValid, oALUResult); end
        n_checks++; if (oMemErr !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky got=%b exp=1", oMemErr); end
    endtask

    task automatic test_reset_busy();
        logic [ADDR_W-1:0] a; logic we, bub, s_rdy, ov, orw, req; logic [15:0] wd, omd, osp; int scnt;
        run_access(1'b1, 1'b0, 1'b1, 2'b01, 16'h0, 16'h7777, 16'h0, 0,
                   a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
        n_checks++; if (osp !== 16'h07FE) begin n_err++; $display("FAIL rb_pre_sp got=%h exp=07fe", osp); end
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 16'h0010, 16'h0, 2'b00);
        @(posedge clk); @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rb_req_busy got=%b exp=1", mem_req); end
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b0; drive_nop();
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rb_req got=%b exp=0", mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL rb_stall got=%b exp=0", stall); end
        n_checks++; if (oSP !== 16'h07FF) begin n_err++; $display("FAIL rb_sp got=%h exp=07ff", oSP); end
        n_checks++; if (oMemErr !== 1'b0) begin n_err++; $display("FAIL rb_err got=%b exp=0", oMemErr); end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 16'h0;
        n_checks++; if (oMemData !== 16'h0 || mem_req !== 1'b0)
            begin n_err++; $display("FAIL rb_late_ready got=%h/%b exp=0000/0", oMemData, mem_req); end
        n_checks++; if (oSP !== 16'h07FF) begin n_err++; $display("FAIL rb_sp_after got=%h exp=07ff", oSP); end
        model_sp = SPMOD - 1;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a; logic we, bub, s_rdy, ov, orw, req; logic [15:0] wd, omd, osp; int scnt;
        logic spo, mw, mr, s; logic [1:0] op; logic [15:0] alu, src, rd;
        int kind, nw, exp_a; logic [15:0] exp_md;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            op   = 2'($urandom_range(0, 3));
            spo  = 1'($urandom_range(0, 1));
            alu  = 16'($urandom); src = 16'($urandom); rd = 16'($urandom);
            if (kind == 0) begin
                @(negedge clk);
                drive_ex(1'b1, 1'b0, 1'b0, spo, 1'b0, 1'b0, 4'h7, alu, src, op);
                #1 s = stall;
                @(posedge clk); @(negedge clk);
                drive_nop();
                model_sp = m_sp(model_sp, op);
                n_checks++; if (s !== 1'b0 || oValid !== 1'b1 || oALUResult !== alu)
                    begin n_err++; $display("FAIL rnd_pass t=%0d got=%b/%b/%h exp=0/1/%h", t, s, oValid, oALUResult, alu); end
                n_checks++; if (oSP !== 16'(model_sp))
                    begin n_err++; $display("FAIL rnd_pass_sp t=%0d got=%h exp=%h", t, oSP, 16'(model_sp)); end
            end else begin
                mw = 1'($urandom_range(0, 1));
                mr = mw ? 1'($urandom_range(0, 1)) : 1'b1;
                nw = $urandom_range(0, 4);
                exp_a = m_addr(model_sp, spo, op, alu);
                run_access(mw, mr, spo, op, alu, src, rd, nw,
                           a, we, wd, bub, scnt, s_rdy, ov, orw, omd, osp, req);
                model_sp = m_sp(model_sp, op);
                exp_md = mw ? 16'h0 : rd;
                n_checks++; if (a !== ADDR_W'(exp_a))
                    begin n_err++; $display("FAIL rnd_addr t=%0d got=%h exp=%h", t, a, ADDR_W'(exp_a)); end
                n_checks++; if (we !== mw || wd !== src)
                    begin n_err++; $display("FAIL rnd_wr t=%0d got=%b/%h exp=%b/%h", t, we, wd, mw, src); end
                n_checks++; if (scnt !== nw + 1 || s_rdy !== 1'b0 || bub !== 1'b0)
                    begin n_err++; $display("FAIL rnd_stall t=%0d got=%0d/%b/%b exp=%0d/0/0", t, scnt, s_rdy, bub, nw + 1); end
                n_checks++; if (ov !== 1'b1 || omd !== exp_md || req !== 1'b0)
                    begin n_err++; $display("FAIL rnd_done t=%0d got=%b/%h/%b exp=1/%h/0", t, ov, omd, req, exp_md); end
                n_checks++; if (osp !== 16'(model_sp))
                    begin n_err++; $display("FAIL rnd_sp t=%0d got=%h exp=%h", t, osp, 16'(model_sp)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_push_pop();
        test_pop_wrap();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
